// File: rtl/escalonador_inversao.sv
// Round-robin arbiter feeding two requesters into one 32-bit byte-reversal stage; MEIA_PALAVRA_EN adds a per-request halfword-swap mode.
// Latency: a word accepted at edge k is on saida_* from edge k; at best one word every two cycles.
// Backpressure: the result is held while saida_ready=0, and both req readys stay low until it is taken.

module escalonador_inversao #(
  parameter int CONT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [31:0]       req0_dados,
`ifdef MEIA_PALAVRA_EN
  input  logic              req0_modo,
`endif
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [31:0]       req1_dados,
`ifdef MEIA_PALAVRA_EN
  input  logic              req1_modo,
`endif
  output logic              req1_ready,
  output logic              saida_valid,
  output logic [31:0]       saida_dados,
  output logic              saida_id,
  input  logic              saida_ready,
  output logic [CONT_W-1:0] contagem
);

  typedef enum logic {
    OCIOSO  = 1'b0,
    ENTREGA = 1'b1
  } estado_t;

  localparam logic [CONT_W-1:0] CONT_UM = CONT_W'(1);

  estado_t     estado;
  estado_t     prox_estado;
  logic        ultimo;
  logic        concede0;
  logic        concede1;
  logic        aceita;
  logic        sel;
  logic        modo_sel;
  logic [31:0] dado_sel;
  logic [31:0] dado_conv;

  // Grant depends only on state, pointer and the valids, never on data.
  always_comb begin
    concede0 = 1'b0;
    concede1 = 1'b0;
    if (estado == OCIOSO) begin
      if (req0_valid && req1_valid) begin
        concede0 = ultimo;
        concede1 = !ultimo;
      end else begin
        concede0 = req0_valid;
        concede1 = req1_valid;
      end
    end
  end

  assign req0_ready = concede0;
  assign req1_ready = concede1;
  assign aceita     = concede0 | concede1;
  assign sel        = concede1;
  assign dado_sel   = sel ? req1_dados : req0_dados;

`ifdef MEIA_PALAVRA_EN
  assign modo_sel = sel ? req1_modo : req0_modo;
`else
  assign modo_sel = 1'b0;
`endif

  always_comb begin
    dado_conv = {dado_sel[7:0], dado_sel[15:8], dado_sel[23:16], dado_sel[31:24]};
    if (modo_sel) begin
      dado_conv = {dado_sel[15:0], dado_sel[31:16]};
    end
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:  if (aceita) prox_estado = ENTREGA;
      ENTREGA: if (saida_ready) prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  // Acceptance only happens in OCIOSO and transfer only in ENTREGA, so the branches never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saida_valid <= 1'b0;
      saida_dados <= '0;
      saida_id    <= 1'b0;
      ultimo      <= 1'b1;
      contagem    <= '0;
    end else if (aceita) begin
      saida_valid <= 1'b1;
      saida_dados <= dado_conv;
      saida_id    <= sel;
      ultimo      <= sel;
    end else if (estado == ENTREGA && saida_ready) begin
      saida_valid <= 1'b0;
      contagem    <= contagem + CONT_UM;
    end
  end

endmodule

// File: tb/tb_escalonador_inversao.sv
// Bench for escalonador_inversao: directed cases from the plan plus random traffic against a transaction-level model.
// A second instance with CONT_W=2 exercises counter wrap on the same stimulus.

module tb_escalonador_inversao;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_dados = '0;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_dados = '0;
  logic        saida_ready = 1'b0;
`ifdef MEIA_PALAVRA_EN
  logic        req0_modo = 1'b0;
  logic        req1_modo = 1'b0;
`endif

  logic        r0, r1, sv, sid;
  logic [31:0] sd;
  logic [15:0] cnt;
  logic        r0b, r1b, svb, sidb;
  logic [31:0] sdb;
  logic [1:0]  cntb;

  escalonador_inversao dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dados(req0_dados),
`ifdef MEIA_PALAVRA_EN
    .req0_modo(req0_modo),
`endif
    .req0_ready(r0),
    .req1_valid(req1_valid), .req1_dados(req1_dados),
`ifdef MEIA_PALAVRA_EN
    .req1_modo(req1_modo),
`endif
    .req1_ready(r1),
    .saida_valid(sv), .saida_dados(sd), .saida_id(sid),
    .saida_ready(saida_ready), .contagem(cnt)
  );

  escalonador_inversao #(.CONT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dados(req0_dados),
`ifdef MEIA_PALAVRA_EN
    .req0_modo(req0_modo),
`endif
    .req0_ready(r0b),
    .req1_valid(req1_valid), .req1_dados(req1_dados),
`ifdef MEIA_PALAVRA_EN
    .req1_modo(req1_modo),
`endif
    .req1_ready(r1b),
    .saida_valid(svb), .saida_dados(sdb), .saida_id(sidb),
    .saida_ready(saida_ready), .contagem(cntb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: a held result, its contents, a completed-transfer count and the last winner.
  bit          m_held;
  logic [31:0] m_dat;
  bit          m_id;
  int unsigned m_cnt;
  bit          m_last;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_held = 1'b0;
    m_dat  = '0;
    m_id   = 1'b0;
    m_cnt  = 0;
    m_last = 1'b1;
  endtask

  function automatic logic [31:0] converte(input logic [31:0] d, input bit meia);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    if (meia) return {d[15:0], d[31:16]};
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic bit modo_of(input int g);
`ifdef MEIA_PALAVRA_EN
    return (g == 1) ? req1_modo : req0_modo;
`else
    return (g < 0);
`endif
  endfunction

  // Winner this cycle from the current inputs, or -1 when nobody is granted.
  function automatic int vencedor();
    if (m_held) return -1;
    if (req0_valid && req1_valid) return (m_last == 1'b1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic sample();
    int g;
    @(negedge clk);
    g = vencedor();
    chk("req0_ready", 32'(r0), 32'(g == 0));
    chk("req1_ready", 32'(r1), 32'(g == 1));
    chk("saida_valid", 32'(sv), 32'(m_held));
    chk("saida_dados", sd, m_dat);
    chk("saida_id", 32'(sid), 32'(m_id));
    chk("contagem", 32'(cnt), 32'(m_cnt[15:0]));
    chk("w2_req0_ready", 32'(r0b), 32'(g == 0));
    chk("w2_req1_ready", 32'(r1b), 32'(g == 1));
    chk("w2_saida_valid", 32'(svb), 32'(m_held));
    chk("w2_saida_dados", sdb, m_dat);
    chk("w2_saida_id", 32'(sidb), 32'(m_id));
    chk("w2_contagem", 32'(cntb), 32'(m_cnt[1:0]));
  endtask

  task automatic advance(input bit keep0, input bit keep1);
    int g;
    g = vencedor();
    if (!rst) begin
      if (g >= 0) begin
        m_held = 1'b1;
        m_dat  = converte((g == 1) ? req1_dados : req0_dados, modo_of(g));
        m_id   = g[0];
        m_last = g[0];
      end else if (m_held && saida_ready) begin
        m_held = 1'b0;
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (g == 0 && !keep0) req0_valid = 1'b0;
    if (g == 1 && !keep1) req1_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1;
    chk("rstasync_valid", 32'(sv), 32'd0);
    chk("rstasync_dados", sd, 32'd0);
    chk("rstasync_contagem", 32'(cnt), 32'd0);
    rst = 1'b0;
    mreset();
  endtask

  logic [31:0] t2_exp [3];
  logic [1:0]  t5_seq [5];

  initial begin
    t2_exp = '{32'hDDCCBBAA, 32'h04030201, 32'hDDCCBBAA};
    t5_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    mreset();

    // Reset state
    sample();
    chk("rst_saida_valid", 32'(sv), 32'd0);
    chk("rst_saida_dados", sd, 32'd0);
    chk("rst_contagem", 32'(cnt), 32'd0);
    chk("rst_req0_ready", 32'(r0), 32'd0);
    chk("rst_req1_ready", 32'(r1), 32'd0);
    advance(0, 0);
    rst = 1'b0;

    // Single word, immediate consumer
    req0_valid = 1'b1; req0_dados = 32'h11223344; saida_ready = 1'b1;
    sample(); chk("t1_req0_ready", 32'(r0), 32'd1); advance(0, 0);
    sample(); chk("t1_dados", sd, 32'h44332211); chk("t1_id", 32'(sid), 32'd0); advance(0, 0);
    sample(); chk("t1_contagem", 32'(cnt), 32'd1); advance(0, 0);

    // Contention from reset alternates, requester 0 first
    pulse_rst();
    req0_valid = 1'b1; req0_dados = 32'hAABBCCDD;
    req1_valid = 1'b1; req1_dados = 32'h01020304;
    saida_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (k % 2 == 1) begin
        chk("t2_dados", sd, t2_exp[k/2]);
        chk("t2_id", 32'(sid), 32'((k / 2) % 2));
      end
      advance(1, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure with a waiting requester
    req0_valid = 1'b1; req0_dados = 32'hDEADBEEF; saida_ready = 1'b0;
    sample(); advance(0, 0);
    req1_valid = 1'b1; req1_dados = 32'h0BADF00D;
    repeat (5) begin
      sample();
      chk("t3_dados", sd, 32'hEFBEADDE);
      chk("t3_valid", 32'(sv), 32'd1);
      chk("t3_req0_ready", 32'(r0), 32'd0);
      chk("t3_req1_ready", 32'(r1), 32'd0);
      chk("t3_contagem", 32'(cnt), 32'd3);
      advance(0, 0);
    end
    saida_ready = 1'b1;
    sample(); advance(0, 0);
    sample(); chk("t3_req1_after", 32'(r1), 32'd1); chk("t3_cnt_after", 32'(cnt), 32'd4); advance(0, 0);
    sample(); chk("t3_dados1", sd, 32'h0DF0AD0B); advance(0, 0);

    // Reset while a result is held
    req0_valid = 1'b1; req0_dados = 32'h12345678; saida_ready = 1'b0;
    sample(); advance(0, 0);
    pulse_rst();
    req0_valid = 1'b1; req1_valid = 1'b1;
    sample(); chk("t4_req0_ready", 32'(r0), 32'd1); chk("t4_req1_ready", 32'(r1), 32'd0); advance(0, 0);
    saida_ready = 1'b1;
    sample(); advance(0, 0);

    // Narrow counter wraps
    pulse_rst();
    req1_valid = 1'b0; saida_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req0_dados = $urandom;
      sample(); advance(0, 0);
      sample(); advance(0, 0);
      chk("t5_contagem_w2", 32'(cntb), 32'(t5_seq[i]));
    end

`ifdef MEIA_PALAVRA_EN
    pulse_rst();
    req1_valid = 1'b1; req1_dados = 32'h11223344; req1_modo = 1'b1;
    sample(); advance(0, 0);
    sample(); chk("t6_meia", sd, 32'h33441122); chk("t6_id", 32'(sid), 32'd1); advance(0, 0);
    req1_valid = 1'b1; req1_modo = 1'b0;
    sample(); advance(0, 0);
    sample(); chk("t6_inteira", sd, 32'h44332211); advance(0, 0);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1; req0_dados = $urandom;
`ifdef MEIA_PALAVRA_EN
        req0_modo = 1'($urandom_range(0, 1));
`endif
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1; req1_dados = $urandom;
`ifdef MEIA_PALAVRA_EN
        req1_modo = 1'($urandom_range(0, 1));
`endif
      end
      saida_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) pulse_rst();
      sample();
      advance(0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
